// File: rtl/poly_chal_pkg.sv
// Shared constants, coefficient encoding and FSM state type for the
// SampleInBall challenge engine (Dilithium2/3/5 selectable at run time).
package poly_chal_pkg;

  localparam int TAU_D2 = 39;
  localparam int TAU_D3 = 49;
  localparam int TAU_D5 = 60;

  localparam logic [1:0] MODE_D2   = 2'd0;
  localparam logic [1:0] MODE_D3   = 2'd1;
  localparam logic [1:0] MODE_D5   = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // Two's-complement style 2-bit code so the sign lives in the top bit.
  localparam logic [1:0] COEF_ZERO = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_NEG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIGNS,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  function automatic int tau_of_mode(input logic [1:0] m);
    case (m)
      MODE_D2: return TAU_D2;
      MODE_D3: return TAU_D3;
      MODE_D5: return TAU_D5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/poly_chal_coef_store.sv
// N x 2-bit challenge coefficient register file with a same-cycle swap write
// and a combinational 32-bit decode. POLY_CHAL_MODQ_EN selects the -1 encoding.
module poly_chal_coef_store
  import poly_chal_pkg::*;
#(
  parameter int N  = 256,
  parameter int Q  = 8380417,
  parameter int IW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            we,
  input  logic [IW-1:0]   idx_i,
  input  logic [IW-1:0]   idx_b,
  input  logic [1:0]      wdat_i,
  input  logic [1:0]      wdat_b,
  output logic [1:0]      rd_b,
  output logic [N*32-1:0] c_out
);

`ifdef POLY_CHAL_MODQ_EN
  localparam bit MODQ_EN = 1'b1;
`else
  localparam bit MODQ_EN = 1'b0;
`endif
  localparam logic [31:0] NEG_WORD = MODQ_EN ? 32'(Q - 1) : 32'hFFFF_FFFF;

  logic [1:0] cells [N];

  function automatic logic [31:0] decode(input logic [1:0] e);
    case (e)
      COEF_POS: return 32'h0000_0001;
      COEF_NEG: return NEG_WORD;
      default:  return 32'h0000_0000;
    endcase
  endfunction

  // The c[b] write is issued last so it wins when idx_i == idx_b.
  always_ff @(posedge clock) begin
    if (!reset_n || clr) begin
      for (int k = 0; k < N; k++) cells[k] <= COEF_ZERO;
    end else if (we) begin
      cells[idx_i] <= wdat_i;
      cells[idx_b] <= wdat_b;
    end
  end

  assign rd_b = cells[idx_b];

  always_comb begin
    c_out = '0;
    for (int k = 0; k < N; k++) c_out[32*k +: 32] = decode(cells[k]);
  end

endmodule

// File: rtl/poly_challenge_stream.sv
// Streaming SampleInBall engine: sign bytes, then rejection-sampled swap
// positions build the sparse +-1 challenge. POLY_CHAL_MODQ_EN picks mod-Q decode.
module poly_challenge_stream
  import poly_chal_pkg::*;
#(
  parameter int N          = 256,
  parameter int SIGN_BYTES = 8,
  parameter int Q          = 8380417
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic [N*32-1:0] c_out,
  output logic [9:0]      bytes_used,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int IW = $clog2(N);
  localparam int SW = $clog2(SIGN_BYTES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [SW-1:0] SIGN_LAST = SW'(SIGN_BYTES - 1);

  state_t                  state;
  logic [IW-1:0]           idx_i;
  logic [SW-1:0]           sign_cnt;
  logic [8*SIGN_BYTES-1:0] sign_word;
  logic                    err_flag;
  logic                    accept;
  logic                    clr;
  logic                    we;
  logic [IW-1:0]           b_idx;
  logic [1:0]              rd_b;
  logic [1:0]              sign_code;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign accept    = byte_valid && byte_ready;
  assign b_idx     = IW'(byte_in);
  assign clr       = (state == ST_IDLE) && start;
  assign we        = (state == ST_SAMPLE) && accept && (b_idx <= idx_i);
  assign sign_code = sign_word[0] ? COEF_NEG : COEF_POS;

  poly_chal_coef_store #(.N(N), .Q(Q), .IW(IW)) u_store (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr),
    .we      (we),
    .idx_i   (idx_i),
    .idx_b   (b_idx),
    .wdat_i  (rd_b),
    .wdat_b  (sign_code),
    .rd_b    (rd_b),
    .c_out   (c_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      bytes_used <= '0;
      idx_i      <= '0;
      sign_cnt   <= '0;
      err_flag   <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (accept) bytes_used <= sat_inc(bytes_used);
      case (state)
        ST_IDLE: begin
          if (start) begin
            bytes_used <= '0;
            sign_cnt   <= '0;
            busy       <= 1'b1;
            if (mode == MODE_RSVD) begin
              err_flag <= 1'b1;
              state    <= ST_FIN;
            end else begin
              err_flag   <= 1'b0;
              idx_i      <= IW'(N - tau_of_mode(mode));
              byte_ready <= 1'b1;
              state      <= ST_SIGNS;
            end
          end
        end
        ST_SIGNS: begin
          if (accept) begin
            sign_cnt <= sign_cnt + 1'b1;
            if (sign_cnt == SIGN_LAST) state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (we) begin
            idx_i <= idx_i + 1'b1;
            if (idx_i == IDX_LAST) begin
              byte_ready <= 1'b0;
              state      <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          error <= err_flag;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sign word: filled little-endian, consumed one bit per accepted position.
  always_ff @(posedge clock) begin
    if ((state == ST_SIGNS) && accept) begin
      sign_word[{sign_cnt, 3'b000} +: 8] <= byte_in;
    end else if (we) begin
      sign_word <= sign_word >> 1;
    end
  end

endmodule

// File: tb/tb_poly_challenge_stream.sv
// Scoreboard bench for poly_challenge_stream: directed runs push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_poly_challenge_stream;

  localparam int N = 256;
`ifdef POLY_CHAL_MODQ_EN
  localparam logic [31:0] NEG = 32'h007F_E000;
`else
  localparam logic [31:0] NEG = 32'hFFFF_FFFF;
`endif
  localparam logic [31:0] POS = 32'h0000_0001;

  typedef struct {
    logic [N*32-1:0] c;
    logic [9:0]      used;
    logic            err;
    int              lat;
    int              w;
    int              t0;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [7:0]      byte_in = 8'd0;
  logic            byte_valid = 1'b0;
  logic            byte_ready;
  logic [N*32-1:0] c_out;
  logic [9:0]      bytes_used;
  logic            busy;
  logic            done;
  logic            error;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dones = 0;
  int   starts = 0;
  int   stalls = 0;
  int   mon_w;
  int   mon_bad;

  poly_challenge_stream dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .c_out      (c_out),
    .bytes_used (bytes_used),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (error) begin
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL error_without_done: error=1 done=%0b, required done=1", done);
      end
    end
    if (done) begin
      dones++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        mon_bad = -1;
        mon_w = 0;
        for (int k = 0; k < N; k++) begin
          if (c_out[32*k +: 32] != 32'h0) mon_w++;
          if (mon_bad < 0 && c_out[32*k +: 32] !== mon_e.c[32*k +: 32]) mon_bad = k;
        end
        checks++;
        if (mon_bad >= 0) begin
          errors++;
          $display("FAIL c_out: coef[%0d]=%08h, required %08h", mon_bad,
                   c_out[32*mon_bad +: 32], mon_e.c[32*mon_bad +: 32]);
        end
        chk("weight", 32'(mon_w), 32'(mon_e.w));
        chk("bytes_used", 32'(bytes_used), 32'(mon_e.used));
        chk("error_flag", 32'(error), 32'(mon_e.err));
        if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
      end
    end
  end

  task automatic do_start(input logic [1:0] m, input exp_t e);
    @(negedge clock);
    mode  = m;
    start = 1'b1;
    e.t0  = cyc;
    sb.push_back(e);
    starts++;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clock);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 50) begin
      stalls++;
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte_ready=0 for 50 cycles, required 1");
    end
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic gap(input int n, input bit poke);
    for (int g = 0; g < n; g++) begin
      @(negedge clock);
      if (poke) begin
        start = 1'b1;
        mode  = 2'd3;
      end
      @(posedge clock);
      #1 start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sb.size() != 0 || busy) && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (guard >= 400) begin
      errors++;
      $display("FAIL run_timeout: pending=%0d busy=%0b after 400 cycles, required 0/0",
               sb.size(), busy);
    end
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_bytes_used"}, 32'(bytes_used), 32'd0);
    chk({tag, "_c_out_nonzero"}, 32'(c_out != '0), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] sg [8];
    int rdy_bad;
    int bit_k;

    // Reset, with a start overlapping the final reset edge.
    repeat (3) @(negedge clock);
    start = 1'b1;
    mode  = 2'd0;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // mode 0, positive signs, positions equal to i: c[217..255] = +1.
    e.c = '0;
    for (int k = 217; k < 256; k++) e.c[32*k +: 32] = POS;
    e.used = 10'd47; e.err = 1'b0; e.lat = 49; e.w = 39; e.t0 = 0;
    do_start(2'd0, e);
    for (int j = 0; j < 8; j++) send_byte(8'h00);
    for (int b = 217; b < 256; b++) send_byte(8'(b));
    wait_idle();

    // Reserved mode: immediate done+error, nothing consumed, storage cleared.
    e.c = '0; e.used = 10'd0; e.err = 1'b1; e.lat = 2; e.w = 0;
    do_start(2'd3, e);
    byte_in = 8'h10;
    byte_valid = 1'b1;
    rdy_bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (byte_ready) rdy_bad++;
    end
    byte_valid = 1'b0;
    chk("mode3_byte_ready_cycles", 32'(rdy_bad), 32'd0);
    wait_idle();

    // mode 0, negative signs, all positions 0: c[0] and c[218..255] = -1.
    e.c = '0;
    e.c[31:0] = NEG;
    for (int k = 218; k < 256; k++) e.c[32*k +: 32] = NEG;
    e.used = 10'd47; e.err = 1'b0; e.lat = 49; e.w = 39;
    do_start(2'd0, e);
    for (int j = 0; j < 8; j++) send_byte(8'hFF);
    for (int b = 0; b < 39; b++) send_byte(8'h00);
    wait_idle();

    // mode 2 with rejected FF bytes, valid gaps and ignored start pulses.
    sg[0] = 8'h55; sg[1] = 8'hAA; sg[2] = 8'h0F; sg[3] = 8'hF0;
    sg[4] = 8'h33; sg[5] = 8'hCC; sg[6] = 8'h01; sg[7] = 8'h09;
    e.c = '0;
    for (int k = 0; k < 60; k++) begin
      bit_k = int'(sg[k/8][k%8]);
      e.c[32*(196+k) +: 32] = (bit_k != 0) ? NEG : POS;
    end
    e.used = 10'd127; e.err = 1'b0; e.lat = -1; e.w = 60;
    stalls = 0;
    do_start(2'd2, e);
    for (int j = 0; j < 8; j++) begin
      send_byte(sg[j]);
      gap(int'($urandom_range(0, 2)), j == 3);
    end
    for (int k = 0; k < 60; k++) begin
      if (k < 59) begin
        send_byte(8'hFF);
        gap(int'($urandom_range(0, 2)), 1'b0);
      end
      send_byte(8'(196 + k));
      if (k < 59) gap(1 + int'($urandom_range(0, 1)), (k % 10) == 5);
    end
    chk("mode2_ready_drops", 32'(stalls), 32'd0);
    wait_idle();

    // Abort a mode 0 run with reset after 20 bytes; no done may follow.
    @(negedge clock);
    mode  = 2'd0;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int j = 0; j < 8; j++) send_byte(8'h00);
    for (int b = 217; b < 229; b++) send_byte(8'(b));
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset_outputs("abort");
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // mode 1 after the abort completes normally.
    e.c = '0;
    for (int k = 207; k < 256; k++) e.c[32*k +: 32] = POS;
    e.used = 10'd57; e.err = 1'b0; e.lat = 59; e.w = 49;
    do_start(2'd1, e);
    for (int j = 0; j < 8; j++) send_byte(8'h00);
    for (int b = 207; b < 256; b++) send_byte(8'(b));
    wait_idle();

    repeat (4) @(negedge clock);
    chk("done_count", 32'(dones), 32'(starts));
    chk("pending_expectations", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_challenge_stream.md
# poly_challenge_stream

Parametrised, mode-selectable SampleInBall engine for the Dilithium signing/verification datapath. Consumes the SHAKE256 squeeze of the challenge seed as a byte stream. Builds the sparse challenge polynomial c: TAU coefficients of ±1, all others 0. Sits between the SHAKE256 core and the NTT/poly-multiply stage, and replaces the fixed-level challenge block with run-time selection of Dilithium2/3/5.

## Interface
- N, 256, polynomial length; coefficient index width is log2(N).
- SIGN_BYTES, 8, stream bytes packed little-endian into the sign word.
- Q, 8380417, modulus used only when POLY_CHAL_MODQ_EN is defined.
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  0: TAU=39, 1: TAU=49, 2: TAU=60, 3: reserved; latched at start.
- byte_in  in  8  squeeze byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  engine accepts a byte this cycle.
- c_out  out  N*32  coefficient k at bits [32k+31:32k].
- bytes_used  out  10  stream bytes consumed by the last run, sign bytes included.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at completion.
- error  out  1  one-cycle pulse together with done when mode==3.

## Operation
- FSM states: IDLE, SIGNS, SAMPLE, FIN.
- IDLE + start, mode<3:
  - clear all coefficients to 0, latch TAU, set i=N-TAU, clear bytes_used, go to SIGNS.
- IDLE + start, mode==3:
  - go to FIN with error set; coefficients cleared; no bytes consumed.
- SIGNS: each accepted byte (byte_valid&&byte_ready) fills sign-word byte j, j=0..7. After the 8th byte, go to SAMPLE.
- SAMPLE: each accepted byte b is handled as follows.
  - b>i: reject the byte; i is unchanged.
  - b<=i: set c[i]=c[b], then c[b] = sign[0] ? -1 : +1. Shift the sign word right by 1 and increment i.
  - When b==i, the final value is the new ±1.
  - After the acceptance at i==N-1, go to FIN.
- FIN: pulse done (and error if set), then return to IDLE.
- Coefficient storage: 2 bits per coefficient (0, +1, -1). c_out is decoded combinationally from it.
- c_out holds its value until the next valid start.
- bytes_used increments on every accepted byte and saturates at 1023.
- start while busy is ignored.
- byte_valid while byte_ready==0 is ignored; no byte is consumed.

## Timing
- reset_n low at an edge: state IDLE, storage all 0, c_out all 0, bytes_used 0, byte_ready 0, busy 0, done 0, error 0. This also applies mid-run: the run is aborted with no done pulse.
- byte_ready = 1 exactly in SIGNS and SAMPLE; it is registered from the state.
- Throughput: at most one byte per cycle; stalls follow byte_valid.
- Latency from start edge to done: 1 + bytes_used accept cycles + stall cycles + 1.
- With no stalls and no rejections: 8 + TAU + 2 cycles.
- mode==3: done and error are high in the 2nd cycle after start.
- Simultaneous start and reset_n low: reset wins.

## Configuration
- POLY_CHAL_MODQ_EN defined:
  - -1 encodes as Q-1 = 32'h007FE000; +1 as 32'h00000001.
- POLY_CHAL_MODQ_EN undefined:
  - -1 encodes as 32'hFFFFFFFF (two's complement); +1 as 32'h00000001.
- 0 is always 32'h0. The macro affects only the c_out decode.

## Structure
- Shared package poly_chal_pkg holds:
  - TAU_D2/TAU_D3/TAU_D5 = 39/49/60 and MODE_* constants;
  - 2-bit coefficient encoding constants;
  - FSM state typedef;
  - a tau_of_mode function.
- Sub-module poly_chal_coef_store: N×2-bit register file with:
  - a read port on b;
  - a dual write (c[i], c[b]) in one cycle, with the c[b] write taking priority when i==b;
  - synchronous clear;
  - decoded c_out.

## Test plan
- mode=0, signs 8×00, then bytes equal to 217..255 in order: coefficients 217..255 = 32'h1, others 0; bytes_used=47; done 49 cycles after start.
- mode=0, signs 8×FF, then 39 bytes of 00:
  - c[0] = -1 encoding; c[217] = 0; c[218..255] = -1 encoding; weight 39.
  - Checked both with and without POLY_CHAL_MODQ_EN.
- mode=2: byte FF (rejected) inserted before each accepted byte, plus random byte_valid gaps:
  - result identical to the gap-free stream; bytes_used = 8 + 60 + rejected count;
  - byte_ready never drops mid-run.
- mode=3 start: done and error pulse together, byte_ready stays 0, c_out is all zero, bytes_used = 0.
- reset_n pulsed low in SAMPLE after 20 bytes:
  - next cycle all outputs at reset values, no done pulse;
  - a following mode=1 run completes normally with weight 49.
- start asserted repeatedly during a run: ignored; exactly one done per accepted start.
